// File: rtl/aq_fdsu_pkg.sv
// Shared definitions for the FDSU left normalizer: state encoding and default widths.
package aq_fdsu_pkg;

  localparam int unsigned FracWDefault = 24;
  localparam int unsigned StepDefault  = 8;
  localparam int unsigned CntWDefault  = 5;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StDone  = 2'b10
  } norm_state_e;

endpackage

// File: rtl/aq_fdsu_lzc8.sv
// Combinational 8-bit leading-zero counter with an all-zero flag.
module aq_fdsu_lzc8 (
  input  logic [7:0] data_i,
  output logic [2:0] cnt_o,
  output logic       zero_o
);

  logic found;

  always_comb begin
    cnt_o = '0;
    found = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (!found && data_i[i]) begin
        cnt_o = 3'(7 - i);
        found = 1'b1;
      end
    end
    zero_o = ~|data_i;
  end

endmodule

// File: rtl/aq_fdsu_left_norm.sv
// Iterative left-shift normalizer: shifts a fraction left until its MSB is set,
// examining STEP bits per cycle, and reports the total shift applied.
module aq_fdsu_left_norm
  import aq_fdsu_pkg::*;
#(
  parameter int unsigned FRAC_W = FracWDefault,
  parameter int unsigned STEP   = StepDefault,
  parameter int unsigned CNT_W  = CntWDefault
) (
  input  logic              forever_cpuclk,
  input  logic              cpurst_b,
  input  logic              norm_in_vld,
  output logic              norm_in_rdy,
  input  logic [FRAC_W-1:0] norm_in_frac,
  input  logic              norm_flush,
  output logic              norm_out_vld,
  input  logic              norm_out_rdy,
  output logic [FRAC_W-1:0] norm_out_frac,
  output logic [CNT_W-1:0]  norm_out_cnt,
  output logic              norm_out_zero
);

  norm_state_e       state_q, state_d;
  logic [FRAC_W-1:0] frac_q, frac_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              zero_q, zero_d;

  logic [2:0] top_lz;
  logic       top_zero;
  logic       rest_zero;

  // The leading-zero counter is fixed at 8 bits, so STEP is expected to be 8.
  aq_fdsu_lzc8 u_lzc (
    .data_i (frac_q[FRAC_W-1 -: 8]),
    .cnt_o  (top_lz),
    .zero_o (top_zero)
  );

  assign rest_zero = ~|frac_q[FRAC_W-STEP-1:0];

  always_comb begin
    state_d = state_q;
    frac_d  = frac_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    if (norm_flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (norm_in_vld) begin
            frac_d  = norm_in_frac;
            cnt_d   = '0;
            zero_d  = 1'b0;
            state_d = StShift;
          end
        end
        StShift: begin
          if (!top_zero) begin
            frac_d  = frac_q << top_lz;
            cnt_d   = cnt_q + CNT_W'(top_lz);
            state_d = StDone;
          end else if (!rest_zero) begin
            frac_d = frac_q << STEP;
            cnt_d  = cnt_q + CNT_W'(STEP);
          end else begin
            frac_d  = '0;
            cnt_d   = '0;
            zero_d  = 1'b1;
            state_d = StDone;
          end
        end
        StDone: begin
          if (norm_out_rdy) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q <= StIdle;
      frac_q  <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      frac_q  <= frac_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
    end
  end

  assign norm_in_rdy   = (state_q == StIdle);
  assign norm_out_vld  = (state_q == StDone);
  assign norm_out_frac = frac_q;
  assign norm_out_cnt  = cnt_q;
  assign norm_out_zero = zero_q;

endmodule

// File: tb/tb_aq_fdsu_left_norm.sv
// Directed self-checking bench for the FDSU left normalizer.
module tb_aq_fdsu_left_norm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_vld = 1'b0;
  logic        in_rdy;
  logic [23:0] in_frac = '0;
  logic        flush = 1'b0;
  logic        out_vld;
  logic        out_rdy = 1'b0;
  logic [23:0] out_frac;
  logic [4:0]  out_cnt;
  logic        out_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  aq_fdsu_left_norm dut (
    .forever_cpuclk (clk),
    .cpurst_b       (rst_n),
    .norm_in_vld    (in_vld),
    .norm_in_rdy    (in_rdy),
    .norm_in_frac   (in_frac),
    .norm_flush     (flush),
    .norm_out_vld   (out_vld),
    .norm_out_rdy   (out_rdy),
    .norm_out_frac  (out_frac),
    .norm_out_cnt   (out_cnt),
    .norm_out_zero  (out_zero)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept a fraction, wait for the result and check latency and outputs; leaves DONE pending.
  task automatic launch(input string tag, input logic [23:0] frac, input logic [23:0] exp_frac,
                        input int exp_cnt, input bit exp_zero, input int exp_lat);
    int lat;
    check({tag, "_in_rdy"}, {31'b0, in_rdy}, 32'd1);
    in_vld  = 1'b1;
    in_frac = frac;
    step();
    in_vld  = 1'b0;
    in_frac = 24'hA5A5A5;
    check({tag, "_busy"}, {31'b0, in_rdy}, 32'd0);
    lat = 0;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (out_vld) begin
        lat = k;
        break;
      end
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_frac"}, {8'b0, out_frac}, {8'b0, exp_frac});
    check({tag, "_cnt"}, {27'b0, out_cnt}, exp_cnt);
    check({tag, "_zero"}, {31'b0, out_zero}, {31'b0, exp_zero});
  endtask

  task automatic consume(input string tag);
    out_rdy = 1'b1;
    step();
    out_rdy = 1'b0;
    check({tag, "_vld_drop"}, {31'b0, out_vld}, 32'd0);
    check({tag, "_idle"}, {31'b0, in_rdy}, 32'd1);
  endtask

  initial begin
    #2;
    check("rst_in_rdy", {31'b0, in_rdy}, 32'd1);
    check("rst_out_vld", {31'b0, out_vld}, 32'd0);
    check("rst_frac", {8'b0, out_frac}, 32'd0);
    check("rst_cnt", {27'b0, out_cnt}, 32'd0);
    check("rst_zero", {31'b0, out_zero}, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    launch("msb", 24'h800000, 24'h800000, 0, 1'b0, 1);
    consume("msb");
    launch("f000", 24'h00F000, 24'hF00000, 8, 1'b0, 2);
    consume("f000");
    launch("one", 24'h000001, 24'h800000, 23, 1'b0, 3);
    consume("one");
    launch("zero", 24'h000000, 24'h000000, 0, 1'b1, 1);
    consume("zero");
    launch("rand", 24'h012345, 24'h91A280, 7, 1'b0, 1);

    // Backpressure: result must hold while the consumer stalls.
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_vld", {31'b0, out_vld}, 32'd1);
      check("bp_in_rdy", {31'b0, in_rdy}, 32'd0);
      check("bp_frac", {8'b0, out_frac}, 32'h0091A280);
      check("bp_cnt", {27'b0, out_cnt}, 32'd7);
    end
    consume("bp");
    launch("after_bp", 24'h0000C0, 24'hC00000, 16, 1'b0, 3);
    consume("after_bp");

    // Flush mid-SHIFT.
    in_vld  = 1'b1;
    in_frac = 24'h000001;
    step();
    in_vld = 1'b0;
    flush  = 1'b1;
    step();
    flush = 1'b0;
    check("flush_idle", {31'b0, in_rdy}, 32'd1);
    check("flush_vld", {31'b0, out_vld}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("flush_no_vld", {31'b0, out_vld}, 32'd0);
    end

    // Flush in IDLE blocks acceptance.
    in_vld  = 1'b1;
    in_frac = 24'h400000;
    flush   = 1'b1;
    step();
    in_vld = 1'b0;
    flush  = 1'b0;
    check("flush_block", {31'b0, in_rdy}, 32'd1);
    step();
    check("flush_block_vld", {31'b0, out_vld}, 32'd0);

    // Flush coinciding with the output handshake.
    launch("fhs", 24'h400000, 24'h800000, 1, 1'b0, 1);
    flush = 1'b1;
    consume("fhs");
    flush = 1'b0;

    // Asynchronous reset mid-SHIFT.
    in_vld  = 1'b1;
    in_frac = 24'h000001;
    step();
    in_vld = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_in_rdy", {31'b0, in_rdy}, 32'd1);
    check("arst_vld", {31'b0, out_vld}, 32'd0);
    check("arst_frac", {8'b0, out_frac}, 32'd0);
    check("arst_cnt", {27'b0, out_cnt}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("arst_rel_rdy", {31'b0, in_rdy}, 32'd1);
    check("arst_rel_vld", {31'b0, out_vld}, 32'd0);
    launch("post_rst", 24'h000300, 24'hC00000, 14, 1'b0, 2);
    consume("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
